// File: rtl/instruction_loader.sv
// Instruction memory loader: assembles little-endian words from a byte stream,
// writes them sequentially from address 0 and releases the CPU on a good checksum.
module instruction_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              error,
  output logic              cpu_rst
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

  typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERROR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   n_words;
  logic [ADDR_W-1:0]   word_idx;
  logic [LANE_W-1:0]   lane;
  logic [7:0]          csum;
  logic [DATA_W-1:0]   word_buf;
  logic [DATA_W-1:0]   next_word;
  logic                xfer;

  assign in_ready = (state == HDR) || (state == DATA) || (state == CSUM);
  assign xfer     = in_valid && in_ready;

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    next_word = word_buf;
    for (int i = 0; i < BYTES; i++) begin
      if (lane == LANE_W'(i)) next_word[i*8 +: 8] = in_data;
    end
  end

  // NOTE: non-blocking assignments for every register so all updates share one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HDR;
      n_words   <= '0;
      word_idx  <= '0;
      lane      <= '0;
      csum      <= '0;
      word_buf  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rst   <= 1'b1;
    end else begin
      mem_we <= 1'b0;
      case (state)
        HDR: begin
          if (xfer) begin
            n_words  <= ADDR_W'(in_data);
            word_idx <= '0;
            lane     <= '0;
            csum     <= '0;
            word_buf <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            csum     <= csum ^ in_data;
            word_buf <= next_word;
            if (lane == LAST_LANE) begin
              lane      <= '0;
              mem_we    <= 1'b1;
              mem_addr  <= word_idx;
              mem_wdata <= next_word;
              word_idx  <= word_idx + ADDR_W'(1);
              // N=0 encodes a full memory, so its last index is all ones.
              if (word_idx == n_words - ADDR_W'(1)) state <= CSUM;
            end else begin
              lane <= lane + LANE_W'(1);
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            if (in_data == csum) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
              state   <= DONE;
            end else begin
              error <= 1'b1;
              state <= ERROR;
            end
          end
        end
        DONE, ERROR: begin
          if (start) begin
            done    <= 1'b0;
            error   <= 1'b0;
            cpu_rst <= 1'b1;
            state   <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule
